// File: rtl/ppu_mmio_regs.sv
// ppu_mmio_regs: PPU register file for 0xFF40-0xFF4B, STAT/VBlank interrupt pulses and OAM DMA engine
`timescale 1ns/1ps
module ppu_mmio_regs #(
  parameter int          DMA_LEN  = 160,
  parameter logic [7:0]  LCDC_RST = 8'h91,
  parameter logic [7:0]  BGP_RST  = 8'hFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_a,
  input  logic [7:0]  mmio_din,
  input  logic        mmio_wr,
  output logic [7:0]  mmio_dout,
  input  logic [1:0]  ppu_mode,
  input  logic [7:0]  ppu_ly,
  output logic [7:0]  lcdc,
  output logic [7:0]  scy,
  output logic [7:0]  scx,
  output logic [7:0]  bgp,
  output logic [7:0]  obp0,
  output logic [7:0]  obp1,
  output logic [7:0]  wy,
  output logic [7:0]  wx,
  output logic        irq_vblank,
  output logic        irq_stat,
  output logic        dma_active,
  output logic [15:0] dma_src_a,
  output logic        dma_rd,
  input  logic [7:0]  dma_rdata,
  output logic [7:0]  oam_dma_a,
  output logic [7:0]  oam_dma_din,
  output logic        oam_dma_wr
);
  localparam logic [7:0] LAST = 8'(DMA_LEN - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dma_state_t;
  dma_state_t state, state_n;
  logic [7:0] idx, idx_n, base, base_n;
  logic [7:0] lyc, dma_reg, rd;
  logic [3:0] stat_en;
  logic [1:0] mode, prev_mode;
  logic       coinc, stat_line, stat_q, dma_start;
  // With the LCD off the PPU is treated as parked in mode 0 and silent
  assign mode      = lcdc[7] ? ppu_mode : 2'd0;
  assign stat_line = lcdc[7] && ((stat_en[3] && coinc) || (stat_en[2] && mode == 2'd2) ||
                                 (stat_en[1] && mode == 2'd1) || (stat_en[0] && mode == 2'd0));
  assign dma_start = mmio_wr && mmio_a == 16'hFF46;
  always_comb begin
    rd = 8'hFF;
    case (mmio_a)
      16'hFF40: rd = lcdc;
      16'hFF41: rd = {1'b1, stat_en, coinc, mode};
      16'hFF42: rd = scy;
      16'hFF43: rd = scx;
      16'hFF44: rd = ppu_ly;
      16'hFF45: rd = lyc;
      16'hFF46: rd = dma_reg;
      16'hFF47: rd = bgp;
      16'hFF48: rd = obp0;
      16'hFF49: rd = obp1;
      16'hFF4A: rd = wy;
      16'hFF4B: rd = wx;
      default:  rd = 8'hFF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lcdc       <= LCDC_RST;
      stat_en    <= '0;
      scy        <= '0;
      scx        <= '0;
      lyc        <= '0;
      dma_reg    <= '0;
      bgp        <= BGP_RST;
      obp0       <= 8'hFF;
      obp1       <= 8'hFF;
      wy         <= '0;
      wx         <= '0;
      mmio_dout  <= 8'hFF;
      coinc      <= 1'b0;
      prev_mode  <= '0;
      stat_q     <= 1'b0;
      irq_stat   <= 1'b0;
      irq_vblank <= 1'b0;
    end else begin
      mmio_dout  <= rd;
      coinc      <= lcdc[7] && ppu_ly == lyc;
      prev_mode  <= ppu_mode;
      stat_q     <= stat_line;
      irq_stat   <= stat_line && !stat_q;
      irq_vblank <= lcdc[7] && ppu_mode == 2'd1 && prev_mode != 2'd1;
      if (mmio_wr) begin
        case (mmio_a)
          16'hFF40: lcdc    <= mmio_din;
          16'hFF41: stat_en <= mmio_din[6:3];
          16'hFF42: scy     <= mmio_din;
          16'hFF43: scx     <= mmio_din;
          16'hFF45: lyc     <= mmio_din;
          16'hFF46: dma_reg <= mmio_din;
          16'hFF47: bgp     <= mmio_din;
          16'hFF48: obp0    <= mmio_din;
          16'hFF49: obp1    <= mmio_din;
          16'hFF4A: wy      <= mmio_din;
          16'hFF4B: wx      <= mmio_din;
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      base  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      base  <= base_n;
    end
  end
  // A new FF46 write always wins, discarding the read already in flight
  always_comb begin
    state_n = state;
    idx_n   = idx;
    base_n  = base;
    if (dma_start) begin
      state_n = RUN;
      idx_n   = '0;
      base_n  = mmio_din;
    end else if (state == RUN) begin
      idx_n   = idx + 8'd1;
      state_n = idx == LAST ? DRAIN : RUN;
    end else if (state == DRAIN) begin
      state_n = IDLE;
    end
  end
  assign dma_active  = state != IDLE;
  assign dma_rd      = state == RUN;
  assign dma_src_a   = dma_rd ? {base, idx} : 16'h0000;
  assign oam_dma_wr  = (state == RUN && idx != 8'd0) || state == DRAIN;
  assign oam_dma_a   = oam_dma_wr ? idx - 8'd1 : 8'h00;
  assign oam_dma_din = oam_dma_wr ? dma_rdata : 8'h00;
endmodule

// File: tb/tb_ppu_mmio_regs.sv
// tb_ppu_mmio_regs: directed register, interrupt and OAM DMA checks for ppu_mmio_regs
`timescale 1ns/1ps
module tb_ppu_mmio_regs;
  logic        clk = 0, rst = 1, mmio_wr = 0;
  logic [15:0] mmio_a = 16'h0000;
  logic [7:0]  mmio_din = 8'h00, ppu_ly = 8'h05, dma_rdata = 8'h00;
  logic [1:0]  ppu_mode = 2'd0;
  logic [7:0]  mmio_dout, lcdc, scy, scx, bgp, obp0, obp1, wy, wx, oam_dma_a, oam_dma_din;
  logic        irq_vblank, irq_stat, dma_active, dma_rd, oam_dma_wr;
  logic [15:0] dma_src_a;
  int          passed = 0, total = 0;
  ppu_mmio_regs dut (
    .clk(clk), .rst(rst), .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_wr(mmio_wr),
    .mmio_dout(mmio_dout), .ppu_mode(ppu_mode), .ppu_ly(ppu_ly), .lcdc(lcdc), .scy(scy),
    .scx(scx), .bgp(bgp), .obp0(obp0), .obp1(obp1), .wy(wy), .wx(wx),
    .irq_vblank(irq_vblank), .irq_stat(irq_stat), .dma_active(dma_active),
    .dma_src_a(dma_src_a), .dma_rd(dma_rd), .dma_rdata(dma_rdata), .oam_dma_a(oam_dma_a),
    .oam_dma_din(oam_dma_din), .oam_dma_wr(oam_dma_wr)
  );
  always #5 clk = ~clk;
  // Source memory: byte at address A holds A[7:0]^0x5A, returned one cycle after the read
  always @(posedge clk) dma_rdata <= dma_src_a[7:0] ^ 8'h5A;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    mmio_a = a;
    mmio_din = d;
    mmio_wr = 1;
    tick();
    mmio_wr = 0;
  endtask
  task automatic rd(input logic [15:0] a);
    mmio_a = a;
    tick();
  endtask
  task automatic run_dma(input logic [7:0] b, input string tag);
    int act = 0, wrs = 0, bad = 0;
    logic [7:0] ea = 0, er = 0;
    while (dma_active === 1'b1 && act < 400) begin
      act++;
      if (dma_rd) begin
        if (dma_src_a !== {b, er}) bad++;
        er++;
      end
      if (oam_dma_wr) begin
        if (oam_dma_a !== ea || oam_dma_din !== (ea ^ 8'h5A)) bad++;
        ea++;
        wrs++;
      end
      tick();
    end
    chk({tag, " active cycles"}, 16'(act), 16'd161);
    chk({tag, " oam writes"}, 16'(wrs), 16'd160);
    chk({tag, " source reads"}, {8'h00, er}, 16'd160);
    chk({tag, " addr/data errors"}, 16'(bad), 16'd0);
    chk({tag, " strobes idle"}, {13'd0, dma_active, dma_rd, oam_dma_wr}, 16'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int ns, nv;
    logic [1:0] seq [5];
    logic [7:0] v;
    seq = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd1};
    tick();
    tick();
    chk("reset dout", {8'h00, mmio_dout}, 16'h00FF);
    chk("reset irq/dma", {11'd0, irq_vblank, irq_stat, dma_active, dma_rd, oam_dma_wr}, 16'd0);
    rst = 0;
    rd(16'hFF40); chk("rd FF40", {8'h00, mmio_dout}, 16'h0091);
    rd(16'hFF47); chk("rd FF47", {8'h00, mmio_dout}, 16'h00FC);
    rd(16'hFF48); chk("rd FF48", {8'h00, mmio_dout}, 16'h00FF);
    rd(16'hFF42); chk("rd FF42", {8'h00, mmio_dout}, 16'h0000);
    rd(16'hFF41); chk("rd FF41", {8'h00, mmio_dout}, 16'h0080);
    rd(16'hFF44); chk("rd FF44 ly", {8'h00, mmio_dout}, 16'h0005);
    rd(16'hFF4C); chk("rd unmapped", {8'h00, mmio_dout}, 16'h00FF);
    // Write held three cycles: first-cycle read returns the old value
    mmio_a = 16'hFF43; mmio_din = 8'h27; mmio_wr = 1;
    tick();
    chk("write-read old", {8'h00, mmio_dout}, 16'h0000);
    tick();
    tick();
    mmio_wr = 0;
    chk("scx port", {8'h00, scx}, 16'h0027);
    chk("scx readback", {8'h00, mmio_dout}, 16'h0027);
    wr(16'hFF44, 8'h77); rd(16'hFF44); chk("LY write ignored", {8'h00, mmio_dout}, 16'h0005);
    wr(16'hFF4A, 8'h33); chk("wy port", {8'h00, wy}, 16'h0033);
    wr(16'hFF41, 8'hFF); rd(16'hFF41); chk("STAT write mask", {8'h00, mmio_dout}, 16'h00F8);
    wr(16'hFF41, 8'h40);
    wr(16'hFF45, 8'h90);
    mmio_a = 16'hFF41;
    tick(); tick(); tick();
    ns = 0;
    for (int i = 0; i < 5; i++) begin
      v = 8'h8E + 8'(i);
      ppu_ly = v;
      tick(); ns += int'(irq_stat);
      tick(); ns += int'(irq_stat);
      chk($sformatf("coinc ly=%h", v), {8'h00, mmio_dout}, v == 8'h90 ? 16'h00C4 : 16'h00C0);
    end
    tick(); ns += int'(irq_stat);
    chk("coinc irq pulses", 16'(ns), 16'd1);
    ppu_mode = 2'd3;
    tick();
    wr(16'hFF41, 8'h08);
    tick(); tick();
    ns = 0; nv = 0;
    for (int i = 0; i < 5; i++) begin
      ppu_mode = seq[i];
      tick();
      if (seq[i] == 2'd1) chk("vblank timing", {15'd0, irq_vblank}, 16'd1);
      if (seq[i] == 2'd0) chk("stat timing", {15'd0, irq_stat}, 16'd1);
      ns += int'(irq_stat); nv += int'(irq_vblank);
      repeat (3) begin
        tick();
        ns += int'(irq_stat); nv += int'(irq_vblank);
      end
    end
    chk("mode stat pulses", 16'(ns), 16'd2);
    chk("vblank pulses", 16'(nv), 16'd1);
    wr(16'hFF40, 8'h11);
    ns = 0; nv = 0;
    ppu_mode = 2'd2; tick(); ns += int'(irq_stat); nv += int'(irq_vblank);
    ppu_mode = 2'd1;
    repeat (3) begin tick(); ns += int'(irq_stat); nv += int'(irq_vblank); end
    ppu_mode = 2'd0;
    repeat (2) begin tick(); ns += int'(irq_stat); nv += int'(irq_vblank); end
    chk("lcd off irqs", 16'(ns + nv), 16'd0);
    ppu_mode = 2'd2;
    rd(16'hFF41); rd(16'hFF41);
    chk("lcd off STAT", {8'h00, mmio_dout}, 16'h0088);
    ppu_mode = 2'd3;
    wr(16'hFF40, 8'h91);
    tick();
    wr(16'hFF46, 8'hC1);
    chk("dma first src", dma_src_a, 16'hC100);
    run_dma(8'hC1, "dma C1");
    chk("rd FF46", {8'h00, mmio_dout}, 16'h00C1);
    wr(16'hFF46, 8'hC1);
    repeat (50) tick();
    chk("pre-restart src", dma_src_a, 16'hC132);
    wr(16'hFF46, 8'hD0);
    chk("restart src", dma_src_a, 16'hD000);
    chk("restart no in-flight wr", {15'd0, oam_dma_wr}, 16'd0);
    run_dma(8'hD0, "dma restart");
    wr(16'hFF46, 8'hD0);
    repeat (80) tick();
    chk("pre-reset src", dma_src_a, 16'hD050);
    chk("pre-reset oam a", {8'h00, oam_dma_a}, 16'h004F);
    rst = 1;
    tick();
    chk("rst dma strobes", {13'd0, dma_active, dma_rd, oam_dma_wr}, 16'd0);
    chk("rst dma addr", dma_src_a | {oam_dma_a, oam_dma_din}, 16'd0);
    chk("rst lcdc", {8'h00, lcdc}, 16'h0091);
    rst = 0;
    rd(16'hFF46); chk("rst FF46", {8'h00, mmio_dout}, 16'h0000);
    wr(16'hFF46, 8'hD0);
    run_dma(8'hD0, "dma after rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
